// File: rtl/load_store_ctrl_pkg.sv
// rtl/load_store_ctrl_pkg.sv - shared types and helpers for the load/store controller
//
// Purpose: access-width encoding, controller state type, output-port address
// default and the access-size helper used by the controller and its aligner.
// Ports: none (package).
package LOAD_STORE_FNS;

  localparam logic [31:0] OUTPORT_ADDR = 32'h0000fffc;

  typedef enum logic [2:0] {
    F3_BYTE   = 3'b000,
    F3_HALF   = 3'b001,
    F3_WORD   = 3'b010,
    F3_BYTE_U = 3'b100,
    F3_HALF_U = 3'b101
  } funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    RESP
  } lsu_state_t;

  // Access size in bytes; 0 marks an illegal encoding.
  function automatic logic [2:0] access_size(input logic [2:0] f3);
    case (f3)
      F3_BYTE, F3_BYTE_U: return 3'd1;
      F3_HALF, F3_HALF_U: return 3'd2;
      F3_WORD:            return 3'd4;
      default:            return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_ctrl_if.sv
// rtl/load_store_ctrl_if.sv - core request/response and data-memory bus bundle
//
// Purpose: groups the core-side req/resp handshake and the word-wide memory
// req/ack bus. slave = controller view, master = core + memory view.
// Signals: req_valid/req_ready/req_is_store/req_funct3/req_addr/req_wdata,
// resp_valid/resp_rdata/resp_err, mem_req/mem_we/mem_addr/mem_be/mem_wdata,
// mem_ack/mem_rdata.
interface load_store_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_ctrl_align.sv
// rtl/load_store_ctrl_align.sv - combinational lane steering and load extension
//
// Purpose: store data/byte-mask placement across a two-word window and load
// extraction with sign/zero extension.
// Ports: funct3, off (byte offset), wdata (right-justified store data),
// lo/hi (first/second memory words) -> st_data (64-bit lane data),
// st_mask (8-bit byte mask), ld_data (extended load result).
module lsu_align
  import LOAD_STORE_FNS::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic [63:0] st_data,
  output logic [7:0]  st_mask,
  output logic [31:0] ld_data
);
  logic [3:0]  size_mask;
  logic [31:0] shifted;

  always_comb begin
    case (access_size(funct3))
      3'd1:    size_mask = 4'b0001;
      3'd2:    size_mask = 4'b0011;
      3'd4:    size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase

    st_data = {32'h0, wdata} << {off, 3'b000};
    st_mask = {4'h0, size_mask} << off;

    shifted = 32'({hi, lo} >> {off, 3'b000});

    case (funct3)
      F3_BYTE:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_HALF:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_WORD:   ld_data = shifted;
      F3_BYTE_U: ld_data = {24'h0, shifted[7:0]};
      F3_HALF_U: ld_data = {16'h0, shifted[15:0]};
      default:   ld_data = 32'h0;
    endcase
  end
endmodule

// File: rtl/load_store_ctrl.sv
// rtl/load_store_ctrl.sv - LOAD/STORE sequencer with misaligned split and output port
//
// Purpose: accepts one access at a time from the core, runs one or two word
// transactions on the data memory (req/ack), assembles/extends load data and
// owns the output-port register at OUTPORT_ADDR (bypasses the memory).
// Ports: clk, rst (async active-high), bus (load_store_ctrl_if.slave: core
// req/resp and memory bus), outport (output-port register).
module load_store_ctrl #(
  parameter logic [31:0] OUTPORT_ADDR     = LOAD_STORE_FNS::OUTPORT_ADDR,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  load_store_ctrl_if.slave    bus,
  output logic [31:0]         outport
);
  import LOAD_STORE_FNS::lsu_state_t;
  import LOAD_STORE_FNS::IDLE;
  import LOAD_STORE_FNS::ACC0;
  import LOAD_STORE_FNS::ACC1;
  import LOAD_STORE_FNS::RESP;
  import LOAD_STORE_FNS::access_size;

  lsu_state_t  state_q, state_d;
  logic        is_store_q, err_q, cross_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q, lo_q, hi_q, resp_rdata_q;

  logic        accept, req_illegal, req_cross, req_err;
  logic [2:0]  req_size;
  logic        in_acc, bypass, done;
  logic [31:0] acc_addr, rd_word, lo_in, hi_in, ld_data, lane_wdata;
  logic [3:0]  lane_be;
  logic [63:0] st_data;
  logic [7:0]  st_mask;

  always_comb begin
    req_size    = access_size(bus.req_funct3);
    req_illegal = (req_size == 3'd0);
    req_cross   = (({1'b0, bus.req_addr[1:0]} + req_size) > 3'd4);
    req_err     = req_illegal || (req_cross && !ALLOW_MISALIGNED);
    accept      = (state_q == IDLE) && bus.req_valid;
  end

  always_comb begin
    in_acc     = (state_q == ACC0) || (state_q == ACC1);
    acc_addr   = {addr_q[31:2], 2'b00} + ((state_q == ACC1) ? 32'd4 : 32'd0);
    // The output-port word never reaches memory; it completes immediately.
    bypass     = in_acc && (acc_addr == OUTPORT_ADDR);
    done       = bypass || (in_acc && bus.mem_ack);
    rd_word    = bypass ? outport : bus.mem_rdata;
    // Present the word arriving this cycle so the final result can be
    // registered on the completing edge.
    lo_in      = (state_q == ACC0) ? rd_word : lo_q;
    hi_in      = (state_q == ACC1) ? rd_word : hi_q;
    lane_be    = (state_q == ACC1) ? st_mask[7:4] : st_mask[3:0];
    lane_wdata = (state_q == ACC1) ? st_data[63:32] : st_data[31:0];
  end

  lsu_align u_align (
    .funct3  (funct3_q),
    .off     (addr_q[1:0]),
    .wdata   (wdata_q),
    .lo      (lo_in),
    .hi      (hi_in),
    .st_data (st_data),
    .st_mask (st_mask),
    .ld_data (ld_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = req_err ? RESP : ACC0;
      ACC0: if (done) state_d = cross_q ? ACC1 : RESP;
      ACC1: if (done) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      is_store_q   <= 1'b0;
      err_q        <= 1'b0;
      cross_q      <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      lo_q         <= 32'h0;
      hi_q         <= 32'h0;
      resp_rdata_q <= 32'h0;
      outport      <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_store_q <= bus.req_is_store;
        funct3_q   <= bus.req_funct3;
        addr_q     <= bus.req_addr;
        wdata_q    <= bus.req_wdata;
        err_q      <= req_err;
        cross_q    <= req_cross;
        hi_q       <= 32'h0;
        if (req_err) resp_rdata_q <= 32'h0;
      end
      if (done) begin
        if (state_q == ACC0) lo_q <= rd_word;
        else                 hi_q <= rd_word;
        if (state_d == RESP) resp_rdata_q <= is_store_q ? 32'h0 : ld_data;
        if (bypass && is_store_q) begin
          for (int i = 0; i < 4; i++) begin
            if (lane_be[i]) outport[8*i +: 8] <= lane_wdata[8*i +: 8];
          end
        end
      end
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = (state_q == RESP) && err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_req    = in_acc && !bypass;
  assign bus.mem_we     = in_acc && is_store_q;
  assign bus.mem_addr   = in_acc ? acc_addr : 32'h0;
  assign bus.mem_be     = in_acc ? lane_be : 4'h0;
  assign bus.mem_wdata  = (in_acc && is_store_q) ? lane_wdata : 32'h0;

endmodule

// File: tb/tb_load_store_ctrl.sv
// tb/tb_load_store_ctrl.sv - directed self-checking bench for load_store_ctrl
module tb_load_store_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  load_store_ctrl_if bus ();
  load_store_ctrl_if bus2 ();
  logic [31:0] outport, outport2;

  load_store_ctrl u_dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .outport (outport)
  );

  load_store_ctrl #(.ALLOW_MISALIGNED(1'b0)) u_dut_nm (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus2.slave),
    .outport (outport2)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int txn_n = 0;
  int req_cyc = 0;
  int resp_at = 0;
  int ack_delay = 0;
  int wcnt = 0;
  bit resp_seen = 1'b0;
  logic [31:0] t_addr [2];
  logic [31:0] t_wdata [2];
  logic [3:0]  t_be [2];
  logic        t_we [2];
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] word_lo = 32'h0;
  logic [31:0] word_hi = 32'h0;

  // Memory model: two words (0x104 -> word_hi, anything else -> word_lo),
  // ack after ack_delay wait cycles.
  assign bus.mem_ack   = bus.mem_req && (wcnt >= ack_delay);
  assign bus.mem_rdata = (bus.mem_addr == 32'h104) ? word_hi : word_lo;
  assign bus2.mem_ack   = bus2.mem_req;
  assign bus2.mem_rdata = 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!bus.mem_req || bus.mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  always @(negedge clk) begin
    if (bus.mem_req) req_cyc = req_cyc + 1;
    if (bus.mem_req && bus.mem_ack) begin
      if (txn_n < 2) begin
        t_addr[txn_n]  = bus.mem_addr;
        t_wdata[txn_n] = bus.mem_wdata;
        t_be[txn_n]    = bus.mem_be;
        t_we[txn_n]    = bus.mem_we;
      end
      txn_n = txn_n + 1;
    end
    if (bus.resp_valid) begin
      resp_seen = 1'b1;
      resp_at   = cyc - t0;
      r_rdata   = bus.resp_rdata;
      r_err     = bus.resp_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
    @(negedge clk);
    t0 = cyc;
    txn_n = 0;
    req_cyc = 0;
    resp_seen = 1'b0;
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag);
    for (int i = 0; i < 40 && !resp_seen; i++) begin
      @(negedge clk);
      #1;
    end
    check({tag, "_resp_seen"}, 32'(resp_seen), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    start_op(st, f3, a, wd);
    wait_resp(tag);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus2.req_valid = 1'b0; bus2.req_is_store = 1'b0; bus2.req_funct3 = 3'b000;
    bus2.req_addr = 32'h0; bus2.req_wdata = 32'h0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_be", 32'(bus.mem_be), 32'h0);
    check("rst_outport", outport, 32'h0);
    check("rst_outport2", outport2, 32'h0);
    rst = 1'b0;

    // LW aligned, immediate ack
    ack_delay = 0; word_lo = 32'hDEADBEEF;
    run_op("lw", 1'b0, 3'b010, 32'h100, 32'h0);
    check("lw_txn_n", txn_n, 1);
    check("lw_addr", t_addr[0], 32'h100);
    check("lw_be", 32'(t_be[0]), 32'hF);
    check("lw_we", 32'(t_we[0]), 32'd0);
    check("lw_lat", resp_at, 2);
    check("lw_rdata", r_rdata, 32'hDEADBEEF);
    check("lw_err", 32'(r_err), 32'd0);

    // LB / LBU of byte 3
    word_lo = 32'h80FF0000;
    run_op("lb", 1'b0, 3'b000, 32'h103, 32'h0);
    check("lb_be", 32'(t_be[0]), 32'h8);
    check("lb_rdata", r_rdata, 32'hFFFFFF80);
    run_op("lbu", 1'b0, 3'b100, 32'h103, 32'h0);
    check("lbu_rdata", r_rdata, 32'h00000080);

    // SW crossing a word boundary
    run_op("sw", 1'b1, 3'b010, 32'h102, 32'h11223344);
    check("sw_txn_n", txn_n, 2);
    check("sw_addr0", t_addr[0], 32'h100);
    check("sw_be0", 32'(t_be[0]), 32'hC);
    check("sw_wdata0", t_wdata[0], 32'h33440000);
    check("sw_we0", 32'(t_we[0]), 32'd1);
    check("sw_addr1", t_addr[1], 32'h104);
    check("sw_be1", 32'(t_be[1]), 32'h3);
    check("sw_wdata1", t_wdata[1], 32'h00001122);
    check("sw_lat", resp_at, 3);
    check("sw_rdata", r_rdata, 32'h0);

    // LH crossing, one wait cycle per transaction: {hi[7:0],lo[31:24]} = 0xF011
    ack_delay = 1; word_lo = 32'h11223344; word_hi = 32'h000000F0;
    run_op("lhx", 1'b0, 3'b001, 32'h103, 32'h0);
    check("lhx_be0", 32'(t_be[0]), 32'h8);
    check("lhx_be1", 32'(t_be[1]), 32'h1);
    check("lhx_rdata", r_rdata, 32'hFFFFF011);
    check("lhx_lat", resp_at, 5);
    ack_delay = 0;

    // Output port bypass
    run_op("sb_out", 1'b1, 3'b000, 32'hfffd, 32'h000000AB);
    check("sb_out_reqs", req_cyc, 0);
    check("sb_out_lat", resp_at, 2);
    check("sb_outport", outport, 32'h0000AB00);
    run_op("lw_out", 1'b0, 3'b010, 32'hfffc, 32'h0);
    check("lw_out_reqs", req_cyc, 0);
    check("lw_out_rdata", r_rdata, 32'h0000AB00);

    // Illegal funct3
    run_op("ill", 1'b0, 3'b011, 32'h100, 32'h0);
    check("ill_err", 32'(r_err), 32'd1);
    check("ill_lat", resp_at, 1);
    check("ill_reqs", req_cyc, 0);
    check("ill_rdata", r_rdata, 32'h0);

    // Misalignment disallowed on the second instance
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_funct3 = 3'b001; bus2.req_addr = 32'h103;
    @(negedge clk);
    bus2.req_valid = 1'b0;
    #1;
    check("nm_resp_valid", 32'(bus2.resp_valid), 32'd1);
    check("nm_err", 32'(bus2.resp_err), 32'd1);
    check("nm_mem_req", 32'(bus2.mem_req), 32'd0);

    // Async reset while waiting on mem_ack
    ack_delay = 100; word_lo = 32'h12345678;
    start_op(1'b0, 3'b010, 32'h100, 32'h0);
    #1;
    check("ar_pre_req", 32'(bus.mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_mem_req", 32'(bus.mem_req), 32'd0);
    check("ar_ready", 32'(bus.req_ready), 32'd1);
    check("ar_outport", outport, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 0;
    run_op("ar_lw", 1'b0, 3'b010, 32'h100, 32'h0);
    check("ar_lw_rdata", r_rdata, 32'h12345678);
    check("ar_lw_lat", resp_at, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
